// File: rtl/fp_compare_pipe_if.sv
// Operand/result handshake bundle for fp_compare_pipe.
// The master drives operands and out_ready; the slave (the comparator) drives the rest.
interface fp_compare_pipe_if #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) ();
    localparam int N = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic         flag;
    logic [N-1:0] result;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, flag, result
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, flag, result
    );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined compare/select for sign/exponent/fraction operands (value = +-0.f * 2^exp).
// Optional saturating transfer counters are built when FP_CMP_STATS_EN is defined.
module fp_compare_pipe #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    fp_compare_pipe_if.slave  bus
`ifdef FP_CMP_STATS_EN
    ,
    output logic [15:0]       stat_true,
    output logic [15:0]       stat_ops
`endif
);
    localparam int N     = 1 + EXP_W + FRAC_W;
    localparam int MAG_W = EXP_W + FRAC_W;

    typedef enum logic [2:0] {
        OP_GT  = 3'd0,
        OP_GE  = 3'd1,
        OP_EQ  = 3'd2,
        OP_LT  = 3'd3,
        OP_LE  = 3'd4,
        OP_MAX = 3'd5,
        OP_MIN = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    // Per-operand field decode; index 0 is A, index 1 is B.
    logic [N-1:0]     w_opnd [2];
    logic [MAG_W-1:0] w_mag  [2];
    logic [1:0]       w_sign;
    logic [1:0]       w_zero;

    assign w_opnd[0] = bus.a;
    assign w_opnd[1] = bus.b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            assign w_sign[gi] = w_opnd[gi][N-1];
            assign w_zero[gi] = (w_opnd[gi][FRAC_W-1:0] == '0);
            assign w_mag[gi]  = w_opnd[gi][MAG_W-1:0];
        end
    endgenerate

    logic         r_s1_valid;
    logic         r_s1_sign_a;
    logic         r_s1_sign_b;
    logic         r_s1_zero_a;
    logic         r_s1_zero_b;
    logic         r_s1_mag_gt;
    logic         r_s1_mag_eq;
    op_e          r_s1_op;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;

    logic         r_out_valid;
    logic         r_flag;
    logic [N-1:0] r_result;

    logic         w_adv2;
    logic         w_in_ready;
    logic         w_in_fire;

    assign w_adv2     = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_adv2;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
        end
    end

    // Payload registers need no reset: they are only consumed when r_s1_valid is set.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_sign_a <= w_sign[0];
            r_s1_sign_b <= w_sign[1];
            r_s1_zero_a <= w_zero[0];
            r_s1_zero_b <= w_zero[1];
            r_s1_mag_gt <= (w_mag[0] > w_mag[1]);
            r_s1_mag_eq <= (w_mag[0] == w_mag[1]);
            r_s1_op     <= op_e'(bus.op);
            r_s1_a      <= bus.a;
            r_s1_b      <= bus.b;
        end
    end

    logic         w_gt;
    logic         w_eq;
    logic         w_flag;
    logic [N-1:0] w_result;

    // Zero handling comes first so a signed zero never reaches the magnitude path.
    always_comb begin
        w_gt = 1'b0;
        if (r_s1_zero_a && r_s1_zero_b) begin
            w_gt = 1'b0;
        end else if (r_s1_zero_a) begin
            w_gt = r_s1_sign_b;
        end else if (r_s1_zero_b) begin
            w_gt = !r_s1_sign_a;
        end else if (r_s1_sign_a != r_s1_sign_b) begin
            w_gt = !r_s1_sign_a;
        end else if (!r_s1_sign_a) begin
            w_gt = r_s1_mag_gt;
        end else begin
            w_gt = !r_s1_mag_gt && !r_s1_mag_eq;
        end
    end

    assign w_eq = (r_s1_zero_a && r_s1_zero_b) ||
                  (!r_s1_zero_a && !r_s1_zero_b &&
                   (r_s1_sign_a == r_s1_sign_b) && r_s1_mag_eq);

    always_comb begin
        w_flag   = 1'b0;
        w_result = r_s1_a;
        case (r_s1_op)
            OP_GT:   w_flag = w_gt;
            OP_GE:   w_flag = w_gt || w_eq;
            OP_EQ:   w_flag = w_eq;
            OP_LT:   w_flag = !w_gt && !w_eq;
            OP_LE:   w_flag = !w_gt;
            OP_MAX: begin
                w_flag   = w_gt || w_eq;
                w_result = (w_gt || w_eq) ? r_s1_a : r_s1_b;
            end
            OP_MIN: begin
                w_flag   = !w_gt;
                w_result = !w_gt ? r_s1_a : r_s1_b;
            end
            OP_RSV:  w_flag = 1'b0;
            default: w_flag = 1'b0;
        endcase
    end

    // Outputs only move when stage 2 advances with a real operation behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_flag      <= 1'b0;
            r_result    <= '0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_flag   <= w_flag;
                r_result <= w_result;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.flag      = r_flag;
    assign bus.result    = r_result;

`ifdef FP_CMP_STATS_EN
    logic        w_out_fire;
    logic [15:0] r_stat_true;
    logic [15:0] r_stat_ops;

    assign w_out_fire = r_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_true <= '0;
            r_stat_ops  <= '0;
        end else if (w_out_fire) begin
            if (r_stat_ops != 16'hFFFF) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_flag && (r_stat_true != 16'hFFFF)) begin
                r_stat_true <= r_stat_true + 16'd1;
            end
        end
    end

    assign stat_true = r_stat_true;
    assign stat_ops  = r_stat_ops;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: directed cases, backpressure, reset mid-stall,
// randomized traffic against a real-valued reference model, and optional counter checks.
`timescale 1ns/1ps
module tb_fp_compare_pipe;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int N      = 1 + EXP_W + FRAC_W;

    typedef struct {
        logic         flag;
        logic [N-1:0] res;
    } exp_t;

    logic clk;
    logic reset;

    fp_compare_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus_if ();

`ifdef FP_CMP_STATS_EN
    logic [15:0] stat_true;
    logic [15:0] stat_ops;
`endif

    fp_compare_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef FP_CMP_STATS_EN
        ,
        .stat_true (stat_true),
        .stat_ops  (stat_ops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   out_cnt = 0;
    bit   quiet   = 1'b0;
    exp_t sb[$];
    int   m_ops  = 0;
    int   m_true = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference model: decode to a real number and compare values directly.
    function automatic real fp_val(input logic [N-1:0] x);
        real v;
        if (x[FRAC_W-1:0] == '0) return 0.0;
        v = (real'(x[FRAC_W-1:0]) / real'(1 << FRAC_W)) * real'(1 << x[N-2:FRAC_W]);
        return x[N-1] ? -v : v;
    endfunction

    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                   input logic [2:0] mop);
        exp_t e;
        real  va, vb;
        bit   gt, eq;
        va = fp_val(ma);
        vb = fp_val(mb);
        gt = (va > vb);
        eq = (va == vb);
        e.res = ma;
        case (mop)
            3'd0: e.flag = gt;
            3'd1: e.flag = gt | eq;
            3'd2: e.flag = eq;
            3'd3: e.flag = !gt & !eq;
            3'd4: e.flag = !gt;
            3'd5: begin e.flag = gt | eq; e.res = (gt | eq) ? ma : mb; end
            3'd6: begin e.flag = !gt;     e.res = !gt ? ma : mb; end
            default: e.flag = 1'b0;
        endcase
        return e;
    endfunction

    // Normalised fraction (MSB set) or zero, so value order matches the field encoding.
    function automatic logic [N-1:0] rand_opnd();
        logic [N-1:0] x;
        x[N-1]        = 1'($urandom_range(0, 1));
        x[N-2:FRAC_W] = EXP_W'($urandom);
        if ($urandom_range(0, 5) == 0) x[FRAC_W-1:0] = '0;
        else x[FRAC_W-1:0] = {1'b1, (FRAC_W-1)'($urandom)};
        return x;
    endfunction

    // Monitor: sampled on the falling edge, the transfer it sees happens at the next rising edge.
    logic         prev_stall = 1'b0;
    logic         prev_flag;
    logic [N-1:0] prev_res;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
            m_ops  = 0;
            m_true = 0;
        end else begin
            chk("in_ready", 32'(bus_if.in_ready),
                32'(!((sb.size() == 2) && !bus_if.out_ready)));
            if (sb.size() == 0) chk("out_valid_empty", 32'(bus_if.out_valid), 32'd0);
            if (prev_stall) begin
                chk("stall_flag", 32'(bus_if.flag), 32'(prev_flag));
                chk("stall_result", 32'(bus_if.result), 32'(prev_res));
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("flag", 32'(bus_if.flag), 32'(e.flag));
                    chk("result", 32'(bus_if.result), 32'(e.res));
                    if (!quiet)
                        $display("[TB] out #%0d flag=%0b result=%h (model flag=%0b result=%h)",
                                 out_cnt, bus_if.flag, bus_if.result, e.flag, e.res);
                end
                out_cnt++;
                if (m_ops < 65535) m_ops++;
                if (bus_if.flag && m_true < 65535) m_true++;
            end
            prev_stall = bus_if.out_valid && !bus_if.out_ready;
            prev_flag  = bus_if.flag;
            prev_res   = bus_if.result;
            if (bus_if.in_valid && bus_if.in_ready)
                sb.push_back(model(bus_if.a, bus_if.b, bus_if.op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty pipe; checks the two-cycle latency and the literal answer.
    task automatic send_check(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                              input logic [2:0] top, input logic ef,
                              input logic [N-1:0] er, input string tag);
        bus_if.in_valid  = 1'b1;
        bus_if.a         = ta;
        bus_if.b         = tb_v;
        bus_if.op        = top;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_accept"}, 32'(bus_if.in_ready), 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(bus_if.out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(bus_if.out_valid), 32'd1);
        chk({tag, "_flag"}, 32'(bus_if.flag), 32'(ef));
        chk({tag, "_res"}, 32'(bus_if.result), 32'(er));
        tick();
    endtask

    task automatic pulse_reset();
        bus_if.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    localparam logic [N-1:0] A1 = 13'b0_1010_10101010;
    localparam logic [N-1:0] B1 = 13'b0_1010_11010111;
    localparam logic [N-1:0] A2 = 13'b1_0110_11101010;
    localparam logic [N-1:0] B2 = 13'b1_1010_11010111;
    localparam logic [N-1:0] B3 = 13'b1_1101_00001100;
    localparam logic [N-1:0] Z0 = 13'b0_0000_00000000;
    localparam logic [N-1:0] Z1 = 13'b1_0000_00000000;
    localparam logic [N-1:0] Z2 = 13'b0_0101_00000000;

    initial begin
        logic [N-1:0] qa[5];
        logic [N-1:0] qb[5];
        logic [2:0]   qo[5];
        int idx, post, out_before, acc, saw_low;

        reset = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.op        = 3'd0;
        bus_if.out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_flag", 32'(bus_if.flag), 32'd0);
        chk("rst_result", 32'(bus_if.result), 32'd0);
        tick();

        // Same-sign positives, sign/exponent cases, zeros, reserved op.
        send_check(A1, B1, 3'd0, 1'b0, A1, "pos_gt");
        send_check(A1, B1, 3'd3, 1'b1, A1, "pos_lt");
        send_check(B1, A1, 3'd0, 1'b1, B1, "swap_gt");
        send_check(A2, B2, 3'd0, 1'b1, A2, "neg_gt");
        send_check(A1, B3, 3'd5, 1'b1, A1, "max");
        send_check(A1, B3, 3'd6, 1'b0, B3, "min");
        send_check(Z0, Z1, 3'd2, 1'b1, Z0, "zero_eq");
        send_check(Z0, Z1, 3'd0, 1'b0, Z0, "zero_gt");
        send_check(Z2, Z1, 3'd2, 1'b1, Z2, "zero_exp_eq");
        send_check(A1, A1, 3'd4, 1'b1, A1, "eq_le");
        send_check(B1, A1, 3'd7, 1'b0, B1, "reserved");

        // Backpressure: five ops, consumer stalls for cycles 3..6.
        for (int i = 0; i < 5; i++) begin
            qa[i] = rand_opnd();
            qb[i] = rand_opnd();
            qo[i] = 3'($urandom_range(0, 6));
        end
        idx = 0; post = 0; saw_low = 0; out_before = out_cnt;
        for (int t = 0; t < 14; t++) begin
            bus_if.out_ready = !(t >= 3 && t < 7);
            if (idx < 5) begin
                bus_if.in_valid = 1'b1;
                bus_if.a  = qa[idx];
                bus_if.b  = qb[idx];
                bus_if.op = qo[idx];
            end else begin
                bus_if.in_valid = 1'b0;
            end
            @(negedge clk);
            acc = (bus_if.in_valid && bus_if.in_ready) ? 1 : 0;
            if (!bus_if.in_ready) saw_low = 1;
            if (t >= 7 && bus_if.out_valid && bus_if.out_ready) post++;
            tick();
            idx += acc;
        end
        chk("bp_in_ready_dropped", 32'(saw_low), 32'd1);
        chk("bp_all_accepted", 32'(idx), 32'd5);
        chk("bp_all_emerged", 32'(out_cnt - out_before), 32'd5);
        chk("bp_full_rate", 32'(post), 32'd4);

        // Reset with both stages full and the consumer stalled.
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.a = B1; bus_if.b = A1; bus_if.op = 3'd0;
        tick();
        bus_if.a = A1; bus_if.b = B3; bus_if.op = 3'd5;
        tick();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("full_flag", 32'(bus_if.flag), 32'd1);
        tick();
        pulse_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("mid_rst_flag", 32'(bus_if.flag), 32'd0);
        chk("mid_rst_result", 32'(bus_if.result), 32'd0);
        tick();
        send_check(A1, B1, 3'd1, 1'b0, A1, "after_rst");

        // Randomized traffic with random bubbles and backpressure.
        for (int t = 0; t < 400; t++) begin
            bus_if.in_valid  = ($urandom_range(0, 3) != 0);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            bus_if.a  = rand_opnd();
            case ($urandom_range(0, 3))
                0: bus_if.b = bus_if.a;
                1: bus_if.b = {~bus_if.a[N-1], bus_if.a[N-2:0]};
                default: bus_if.b = rand_opnd();
            endcase
            bus_if.op = 3'($urandom);
            tick();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", 32'(sb.size()), 32'd0);

`ifdef FP_CMP_STATS_EN
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.op = 3'd0;
            bus_if.a  = (i < 4) ? B1 : A1;
            bus_if.b  = (i < 4) ? A1 : B1;
            tick();
        end
        bus_if.in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("stat_ops_10", 32'(stat_ops), 32'd10);
        chk("stat_true_4", 32'(stat_true), 32'd4);
        tick();
        quiet = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.a = A1; bus_if.b = A1; bus_if.op = 3'd1;
        repeat (65540) tick();
        bus_if.in_valid = 1'b0;
        repeat (4) tick();
        quiet = 1'b0;
        @(negedge clk);
        chk("stat_ops_sat", 32'(stat_ops), 32'hFFFF);
        chk("stat_true_sat", 32'(stat_true), 32'hFFFF);
        chk("stat_ops_model", 32'(stat_ops), 32'(m_ops));
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
